mmio_out_port: RTL
==================

Name: mmio_out_port

Overview:
- Memory-mapped output device for the multi-cycle MIPS machine.
- It is the counterpart of the machine's 32-bit input port: the CPU stores words to it, and they leave through a valid/ready stream to the external consumer (testbench monitor or display).
- It sits on the CPU data-memory bus beside data memory and is selected by address decode.
- A small FIFO decouples CPU stores from consumer backpressure.

Parameters:
- BASE_ADDR, 32'h0000_7F00, 16-byte-aligned base of the register window.
- DEPTH_LOG2, 2, log2 of FIFO depth (default depth 4).

Ports:
- clk  in  1  system clock, posedge.
- rst  in  1  reset. Synchronous, active-low.
- mem_we  in  1  CPU store strobe for this cycle.
- mem_addr  in  32  CPU byte address.
- mem_wdata  in  32  CPU store data.
- mem_rdata  out  32  read data, combinational from mem_addr.
- sel  out  1  high when mem_addr is inside the window; used by the bus read mux.
- out_data  out  32  FIFO head word.
- out_valid  out  1  out_data is valid.
- out_ready  in  1  consumer accepts the word.

Behaviour:
- Decode:
  - sel = (mem_addr[31:4] == BASE_ADDR[31:4]).
  - Register offset = mem_addr[3:2]; mem_addr[1:0] are ignored.
  - Offset 0 = DATA, 1 = STATUS, 2 = CTRL, 3 = unmapped.
  - Unmapped reads return 0 and unmapped writes are ignored.
  - When sel = 0, mem_rdata = 0.
- Reset: at a posedge with rst = 0:
  - FIFO empty, count = 0, out_valid = 0, out_data = 0.
  - enable = 1.
  - ovf = 0, ovf_cnt = 0, DATA shadow = 0.
  - Reset overrides every other event in the same cycle.
- Push: mem_we & sel & offset 0.
  - If not full, or a pop occurs in the same cycle, the word is written at the tail and the shadow is updated.
  - If full with no simultaneous pop, the word is dropped, ovf is set (sticky) and ovf_cnt increments, saturating at 255. The shadow is still updated.
- Pop: out_valid & out_ready advances the head.
- Outputs:
  - out_valid = enable & !empty.
  - out_data = head entry, and is 0 when empty.
  - Data must stay stable while out_valid = 1 and out_ready = 0.
- Latency: a push into an empty FIFO shows out_valid = 1 in the cycle after the store edge. There is no combinational bypass.
- Simultaneous push and pop:
  - Count is unchanged.
  - If full, the push is accepted.
  - If the FIFO has one entry, the head pops and the new word becomes the head.
- Pointers: DEPTH_LOG2-bit read and write pointers wrap modulo depth. count is DEPTH_LOG2+1 bits (0..depth). full = (count == depth).
- CTRL write: mem_we & sel & offset 2.
  - bit0 → enable.
  - bit1 = 1 → flush, effective at that edge: count = 0, pointers = 0, ovf = 0, ovf_cnt = 0.
  - A pop in the same cycle is discarded by the flush.
  - bit1 self-clears and reads back 0.
- enable = 0:
  - out_valid is forced low.
  - Pushes are still accepted.
  - Contents are preserved and are presented again when enable returns to 1.
- STATUS read, bit layout:
  - [DEPTH_LOG2:0] count, zero-extended.
  - [8] empty.
  - [9] full.
  - [10] ovf.
  - [23:16] ovf_cnt.
  - All other bits are 0.
- DATA read returns the shadow, i.e. the last stored word.
- CTRL read returns {31'b0, enable}.
- STATUS and CTRL are read-only from the CPU side; stores to STATUS are ignored.

Decomposition:
- Shared package:
  - Register offset constants: OFF_DATA = 2'd0, OFF_STATUS = 2'd1, OFF_CTRL = 2'd2.
  - STATUS bit positions: ST_EMPTY = 8, ST_FULL = 9, ST_OVF = 10, ST_OVFCNT_LSB = 16.
  - CTRL bit positions: CTRL_EN = 0, CTRL_FLUSH = 1.
- Sub-module sync_fifo (parameter DEPTH_LOG2, WIDTH = 32):
  - Ports: push, pop, flush, din, dout, count, full, empty.
  - The top level keeps decode, shadow, ovf logic and CTRL.

Test Plan:
- Reset, then store 0x11, 0x22, 0x33 to BASE with out_ready = 1 → out_data sequence 0x11, 0x22, 0x33; the first out_valid appears 1 cycle after the first store; STATUS count returns to 0 and empty = 1.
- out_ready = 0, store 5 words 0xA0..0xA4 at depth 4:
  - STATUS reads full = 1, count = 4, ovf = 1, ovf_cnt = 1.
  - After releasing out_ready, the consumer sees 0xA0..0xA3; 0xA4 is dropped.
  - DATA reads 0xA4.
- FIFO full with out_ready = 1, store 0xB5 in the same cycle as a pop → count stays 4, ovf stays 0, and 0xB5 is delivered last.
- Store CTRL = 0, push 0x80 → out_valid stays 0 for 10 cycles. Then store CTRL = 1 → out_valid = 1 with out_data = 0x80.
- Three words queued, out_ready = 1, store CTRL = 3 → the next cycle shows count = 0, out_valid = 0, ovf_cnt = 0, and the popped word is not delivered twice.
- Words queued, drive rst = 0 for one edge mid-stream → all outputs reach their reset values. A store to BASE+0xC is ignored, and reading BASE+0xC returns 0.

Source files
------------

// File: rtl/mmio_out_port_pkg.sv
// rtl/mmio_out_port_pkg.sv - register map constants shared by the MMIO output port
package mmio_out_port_pkg;

   // Register offsets, selected by mem_addr[3:2]
   localparam logic [1:0] OFF_DATA   = 2'd0;
   localparam logic [1:0] OFF_STATUS = 2'd1;
   localparam logic [1:0] OFF_CTRL   = 2'd2;

   // STATUS bit positions (count occupies the low bits)
   localparam int ST_EMPTY      = 8;
   localparam int ST_FULL       = 9;
   localparam int ST_OVF        = 10;
   localparam int ST_OVFCNT_LSB = 16;

   // CTRL bit positions
   localparam int CTRL_EN    = 0;
   localparam int CTRL_FLUSH = 1;

endpackage

// File: rtl/mmio_out_port_sync_fifo.sv
// rtl/mmio_out_port_sync_fifo.sv - synchronous FIFO behind the MMIO output port
//
// Ports:
//   clk, rst     posedge clock, synchronous active-low reset
//   push, din    write din at the tail (dropped when full unless popping)
//   pop          advance the head (ignored when empty)
//   flush        empty the FIFO at this edge; overrides push and pop
//   dout         head entry, 0 when empty
//   count        occupancy 0..depth
//   full, empty  occupancy flags
module sync_fifo #(
   parameter int DEPTH_LOG2 = 2,
   parameter int WIDTH      = 32
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  push,
   input  logic                  pop,
   input  logic                  flush,
   input  logic [WIDTH-1:0]      din,
   output logic [WIDTH-1:0]      dout,
   output logic [DEPTH_LOG2:0]   count,
   output logic                  full,
   output logic                  empty
);

   localparam int DEPTH = 1 << DEPTH_LOG2;
   localparam logic [DEPTH_LOG2-1:0] PTR_ONE = DEPTH_LOG2'(1);
   localparam logic [DEPTH_LOG2:0]   CNT_ONE = (DEPTH_LOG2 + 1)'(1);

   logic [WIDTH-1:0]      mem [DEPTH];
   logic [DEPTH_LOG2-1:0] rd_ptr;
   logic [DEPTH_LOG2-1:0] wr_ptr;
   logic                  do_push;
   logic                  do_pop;

   assign empty = (count == '0);
   assign full  = (count == (DEPTH_LOG2 + 1)'(DEPTH));

   // A pop frees a slot in the same edge, so a full FIFO still takes a push.
   assign do_pop  = pop & ~empty;
   assign do_push = push & (~full | do_pop);

   assign dout = empty ? '0 : mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (!rst || flush) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push)
            wr_ptr <= wr_ptr + PTR_ONE;
         if (do_pop)
            rd_ptr <= rd_ptr + PTR_ONE;
         case ({do_push, do_pop})
            2'b10:   count <= count + CNT_ONE;
            2'b01:   count <= count - CNT_ONE;
            default: count <= count;
         endcase
      end
   end

   // Storage needs no reset: dout is masked while empty.
   always_ff @(posedge clk) begin
      if (rst && !flush && do_push)
         mem[wr_ptr] <= din;
   end

endmodule

// File: rtl/mmio_out_port.sv
// rtl/mmio_out_port.sv - memory-mapped CPU output port feeding a valid/ready stream
//
// Ports:
//   clk, rst            posedge clock, synchronous active-low reset
//   mem_we              CPU store strobe
//   mem_addr, mem_wdata CPU byte address and store data
//   mem_rdata           register read data, combinational from mem_addr
//   sel                 mem_addr falls in this device's 16-byte window
//   out_data, out_valid stream word and qualifier towards the consumer
//   out_ready           consumer accepts out_data
//
// Window: +0 DATA (push / last stored word), +4 STATUS, +8 CTRL, +C unmapped.
module mmio_out_port
   import mmio_out_port_pkg::*;
#(
   parameter logic [31:0] BASE_ADDR  = 32'h0000_7F00,
   parameter int          DEPTH_LOG2 = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        mem_we,
   input  logic [31:0] mem_addr,
   input  logic [31:0] mem_wdata,
   output logic [31:0] mem_rdata,
   output logic        sel,
   output logic [31:0] out_data,
   output logic        out_valid,
   input  logic        out_ready
);

   logic [1:0]            offset;
   logic                  wr_data;
   logic                  wr_ctrl;
   logic                  flush;
   logic                  pop;
   logic                  ovf_event;
   logic                  enable;
   logic                  ovf;
   logic [7:0]            ovf_cnt;
   logic [31:0]           shadow;
   logic [31:0]           status;
   logic [DEPTH_LOG2:0]   count;
   logic                  full;
   logic                  empty;
   logic                  unused_addr_bits;

   assign unused_addr_bits = ^mem_addr[1:0];

   assign sel     = (mem_addr[31:4] == BASE_ADDR[31:4]);
   assign offset  = mem_addr[3:2];
   assign wr_data = mem_we & sel & (offset == OFF_DATA);
   assign wr_ctrl = mem_we & sel & (offset == OFF_CTRL);
   assign flush   = wr_ctrl & mem_wdata[CTRL_FLUSH];

   assign out_valid = enable & ~empty;
   assign pop       = out_valid & out_ready;

   // Dropped store: only when no pop makes room at this same edge.
   assign ovf_event = wr_data & full & ~pop;

   sync_fifo #(
      .DEPTH_LOG2 (DEPTH_LOG2),
      .WIDTH      (32)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (wr_data),
      .pop   (pop & ~flush),
      .flush (flush),
      .din   (mem_wdata),
      .dout  (out_data),
      .count (count),
      .full  (full),
      .empty (empty)
   );

   always_ff @(posedge clk) begin
      if (!rst) begin
         enable  <= 1'b1;
         ovf     <= 1'b0;
         ovf_cnt <= 8'd0;
         shadow  <= 32'd0;
      end else begin
         if (wr_data)
            shadow <= mem_wdata;
         if (wr_ctrl)
            enable <= mem_wdata[CTRL_EN];
         if (flush) begin
            ovf     <= 1'b0;
            ovf_cnt <= 8'd0;
         end else if (ovf_event) begin
            ovf <= 1'b1;
            if (ovf_cnt != 8'hFF)
               ovf_cnt <= ovf_cnt + 8'd1;
         end
      end
   end

   always_comb begin
      status                           = '0;
      status[DEPTH_LOG2:0]             = count;
      status[ST_EMPTY]                 = empty;
      status[ST_FULL]                  = full;
      status[ST_OVF]                   = ovf;
      status[ST_OVFCNT_LSB +: 8]       = ovf_cnt;
   end

   always_comb begin
      mem_rdata = 32'd0;
      if (sel) begin
         case (offset)
            OFF_DATA:   mem_rdata = shadow;
            OFF_STATUS: mem_rdata = status;
            OFF_CTRL:   mem_rdata = {31'd0, enable};
            default:    mem_rdata = 32'd0;
         endcase
      end
   end

endmodule
